// File: rtl/key_event_merger.sv
// Merges NUM_KEYS raw key lines into a debounced held-key bitmap and a queued
// stream of press/release events delivered over a valid/ready handshake.
module key_event_merger #(
    parameter int                  NUM_KEYS     = 16,
    parameter int                  IDX_W        = 6,
    parameter int                  DEBOUNCE_CNT = 500000,
    parameter int                  FIFO_DEPTH   = 8,
    parameter logic [NUM_KEYS-1:0] INVERT_MASK  = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_KEYS-1:0]           raw_keys,
    input  logic                          clr_overflow,
    output logic [NUM_KEYS-1:0]           key_state,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [IDX_W-1:0]              evt_idx,
    output logic                          evt_press,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             press;
    } evt_t;

    logic [NUM_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] stable_q, stable_d, pend_q, pend_d, ptype_q, ptype_d;
    logic [NUM_KEYS-1:0] flip, wr_sel;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                overflow_q, overflow_d;
    evt_t                mem_q [FIFO_DEPTH];
    evt_t                wr_evt, head;
    logic                push, pop, full, drop;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        sync1_d  = raw_keys ^ INVERT_MASK;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        flip     = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CNT - 1)) begin
                    flip[i]     = 1'b1;
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        full   = (count_q == (PTR_W+1)'(FIFO_DEPTH));
        wr_evt = '0;
        wr_sel = '0;
        // Descending scan so the lowest pending index is the one that sticks.
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                wr_evt.idx   = IDX_W'(i);
                wr_evt.press = ptype_q[i];
                wr_sel       = '0;
                wr_sel[i]    = 1'b1;
            end
        end
        push = (|pend_q) && !full;
        pop  = (count_q != '0) && evt_ready;

        pend_d  = push ? (pend_q & ~wr_sel) : pend_q;
        ptype_d = ptype_q;
        drop    = 1'b0;
        // A flip on a key whose previous event is still unqueued cancels both.
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (flip[i]) begin
                if (pend_d[i]) begin
                    pend_d[i] = 1'b0;
                    drop      = 1'b1;
                end else begin
                    pend_d[i]  = 1'b1;
                    ptype_d[i] = stable_d[i];
                end
            end
        end

        if (drop)              overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
        else                   overflow_d = overflow_q;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            pend_q     <= '0;
            ptype_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            pend_q     <= pend_d;
            ptype_q    <= ptype_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // NOTE: queue storage is not reset; the head fields are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_evt;
    end

    assign head      = mem_q[rd_ptr_q];
    assign evt_valid = (count_q != '0);
    assign evt_idx   = evt_valid ? head.idx : '0;
    assign evt_press = evt_valid ? head.press : 1'b0;
    assign evt_count = count_q;
    assign key_state = stable_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_merger.sv
// Directed bench for key_event_merger: expected events are queued as keys are
// driven and compared as the DUT hands them over.
module tb_key_event_merger;

    typedef struct packed {
        logic [5:0] idx;
        logic       press;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] raw_keys;
    logic        clr_overflow;
    logic [15:0] key_state;
    logic        evt_valid, evt_ready, evt_press, overflow;
    logic [5:0]  evt_idx;
    logic [2:0]  evt_count;

    logic [15:0] raw_inv;
    logic [15:0] key_state_inv;
    logic        valid_inv, ready_inv, press_inv, overflow_inv;
    logic [5:0]  idx_inv;
    logic [2:0]  count_inv;

    int   checks = 0;
    int   errors = 0;
    evt_t sb[$];

    always #5 clk = ~clk;

    key_event_merger #(
        .NUM_KEYS(16), .IDX_W(6), .DEBOUNCE_CNT(4), .FIFO_DEPTH(4), .INVERT_MASK(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .raw_keys(raw_keys), .clr_overflow(clr_overflow),
        .key_state(key_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_idx(evt_idx), .evt_press(evt_press), .evt_count(evt_count), .overflow(overflow)
    );

    key_event_merger #(
        .NUM_KEYS(16), .IDX_W(6), .DEBOUNCE_CNT(4), .FIFO_DEPTH(4), .INVERT_MASK(16'h0001)
    ) dut_inv (
        .clk(clk), .rst(rst), .raw_keys(raw_inv), .clr_overflow(1'b0),
        .key_state(key_state_inv), .evt_valid(valid_inv), .evt_ready(ready_inv),
        .evt_idx(idx_inv), .evt_press(press_inv), .evt_count(count_inv), .overflow(overflow_inv)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int key, input logic press);
        sb.push_back('{idx: 6'(key), press: press});
    endtask

    // Compares any handshake about to complete on the next edge, then advances one cycle.
    task automatic cycle();
        evt_t exp;
        if (evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_event: observed idx %0d press %0d expected none",
                       evt_idx, evt_press);
            end else begin
                exp = sb.pop_front();
                check("sb_idx", 64'(evt_idx), 64'(exp.idx));
                check("sb_press", 64'(evt_press), 64'(exp.press));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            cycle();
            n++;
        end
        check("drain_sb_left", 64'(sb.size()), 0);
        check("drain_count", 64'(evt_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        raw_keys     = '0;
        raw_inv      = '0;
        clr_overflow = 1'b0;
        evt_ready    = 1'b0;
        ready_inv    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_key_state", 64'(key_state), 0);
        check("rst_valid", 64'(evt_valid), 0);
        check("rst_idx", 64'(evt_idx), 0);
        check("rst_press", 64'(evt_press), 0);
        check("rst_count", 64'(evt_count), 0);
        check("rst_overflow", 64'(overflow), 0);

        // Reset in the middle of debouncing key 3 discards it.
        raw_keys[3] = 1'b1;
        repeat (3) cycle();
        rst = 1'b1;
        #1;
        check("midrst_key_state", 64'(key_state), 0);
        check("midrst_count", 64'(evt_count), 0);
        @(negedge clk);
        raw_keys[3] = 1'b0;
        cycle();
        rst = 1'b0;
        repeat (10) cycle();
        check("midrst_after_ks", 64'(key_state), 0);
        check("midrst_after_valid", 64'(evt_valid), 0);

        // Key 5 press: key_state at edge 6, event at edge 7; then release.
        raw_keys[5] = 1'b1;
        push_exp(5, 1'b1);
        repeat (5) cycle();
        check("k5_edge5_ks", 64'(key_state), 0);
        cycle();
        check("k5_edge6_ks", 64'(key_state), 64'h0020);
        check("k5_edge6_valid", 64'(evt_valid), 0);
        evt_ready = 1'b1;
        cycle();
        check("k5_edge7_valid", 64'(evt_valid), 1);
        check("k5_edge7_idx", 64'(evt_idx), 5);
        check("k5_edge7_press", 64'(evt_press), 1);
        check("k5_edge7_count", 64'(evt_count), 1);
        cycle();
        check("k5_popped_count", 64'(evt_count), 0);
        raw_keys[5] = 1'b0;
        push_exp(5, 1'b0);
        repeat (6) cycle();
        check("k5_rel_ks", 64'(key_state), 0);
        cycle();
        check("k5_rel_valid", 64'(evt_valid), 1);
        check("k5_rel_press", 64'(evt_press), 0);
        cycle();
        check("k5_rel_count", 64'(evt_count), 0);

        // Three-cycle glitch on key 2 is rejected.
        raw_keys[2] = 1'b1;
        repeat (3) cycle();
        raw_keys[2] = 1'b0;
        repeat (8) cycle();
        check("glitch_ks", 64'(key_state), 0);
        check("glitch_count", 64'(evt_count), 0);

        // Simultaneous presses come out lowest index first on consecutive edges.
        raw_keys = raw_keys | 16'h0212;
        push_exp(1, 1'b1);
        push_exp(4, 1'b1);
        push_exp(9, 1'b1);
        repeat (6) cycle();
        check("multi_ks", 64'(key_state), 64'h0212);
        cycle();
        check("multi_idx_e7", 64'(evt_idx), 1);
        cycle();
        check("multi_idx_e8", 64'(evt_idx), 4);
        cycle();
        check("multi_idx_e9", 64'(evt_idx), 9);
        drain();
        raw_keys = raw_keys & ~16'h0212;
        push_exp(1, 1'b0);
        push_exp(4, 1'b0);
        push_exp(9, 1'b0);
        drain();
        check("multi_rel_ks", 64'(key_state), 0);

        // Six presses into a stalled four-deep queue: two wait as pending, none lost.
        evt_ready = 1'b0;
        raw_keys = 16'hFC00;
        for (int k = 10; k < 16; k++) push_exp(k, 1'b1);
        repeat (12) cycle();
        check("full_count", 64'(evt_count), 4);
        check("full_pend", 64'($countones(dut.pend_q)), 2);
        check("full_overflow", 64'(overflow), 0);
        check("full_head_idx", 64'(evt_idx), 10);
        evt_ready = 1'b1;
        drain();
        check("full_ks", 64'(key_state), 64'hFC00);
        raw_keys = '0;
        for (int k = 10; k < 16; k++) push_exp(k, 1'b0);
        drain();

        // Press/release pair on key 7 while the queue is full is dropped.
        evt_ready = 1'b0;
        raw_keys = 16'h3C00;
        for (int k = 10; k < 14; k++) push_exp(k, 1'b1);
        repeat (10) cycle();
        check("ovf_fill_count", 64'(evt_count), 4);
        raw_keys[7] = 1'b1;
        repeat (6) cycle();
        check("ovf_k7_ks", 64'(key_state), 64'h3C80);
        check("ovf_before", 64'(overflow), 0);
        raw_keys[7] = 1'b0;
        repeat (6) cycle();
        check("ovf_set", 64'(overflow), 1);
        check("ovf_ks", 64'(key_state), 64'h3C00);
        check("ovf_count", 64'(evt_count), 4);
        clr_overflow = 1'b1;
        cycle();
        clr_overflow = 1'b0;
        check("ovf_cleared", 64'(overflow), 0);
        evt_ready = 1'b1;
        drain();
        raw_keys = '0;
        for (int k = 10; k < 14; k++) push_exp(k, 1'b0);
        drain();

        // Active-low key 0 held low since reset reads as a press.
        check("inv_valid", 64'(valid_inv), 1);
        check("inv_idx", 64'(idx_inv), 0);
        check("inv_press", 64'(press_inv), 1);
        check("inv_count", 64'(count_inv), 1);
        check("inv_ks", 64'(key_state_inv), 64'h0001);
        ready_inv = 1'b1;
        cycle();
        check("inv_popped", 64'(valid_inv), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_merger.md
Name: key_event_merger

Overview:
- Parametrised successor to the ad-hoc keypad/button merge logic in the top level.
- Takes NUM_KEYS raw key lines (keypad scan bits plus discrete buttons) and runs each through a 2-flop synchroniser and a debounce counter.
- Reports a debounced held-key bitmap and a queued stream of press/release events (key index + type) over a valid/ready handshake.
- Sits between the input sources and the display/application logic, replacing level-OR "valid" with per-key edge events.

Parameters:
- NUM_KEYS, 16, number of key lines merged (1..64).
- IDX_W, 6, width of the event key index; must satisfy 2**IDX_W >= NUM_KEYS.
- DEBOUNCE_CNT, 500000, consecutive stable cycles required to accept a level change (>=2; 10 ms at 50 MHz).
- FIFO_DEPTH, 8, event queue depth (power of 2, >=2).
- INVERT_MASK, 0, per-key polarity; bit i = 1 means raw_keys[i] is active-low.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- raw_keys  in  NUM_KEYS  unsynchronised key levels; bit i is key index i.
- clr_overflow  in  1  synchronous clear of the overflow flag.
- key_state  out  NUM_KEYS  debounced levels, 1 = pressed after INVERT_MASK is applied.
- evt_valid  out  1  event queue non-empty.
- evt_ready  in  1  consumer accepts the head event.
- evt_idx  out  IDX_W  key index of the head event.
- evt_press  out  1  head event type: 1 = press, 0 = release.
- evt_count  out  clog2(FIFO_DEPTH)+1  number of queued events.
- overflow  out  1  sticky; at least one event has been lost.

Behaviour:
- Reset (asynchronous, active-high):
  - Synchroniser flops, stable levels and debounce counters clear to 0; every key is treated as released.
  - Pending bits, FIFO pointers and evt_count clear to 0.
  - evt_valid, evt_idx, evt_press and overflow clear to 0.
  - Reset mid-debounce or with a non-empty queue discards all state; no events are emitted for keys already held when reset releases.
- Polarity: n[i] = raw_keys[i] XOR INVERT_MASK[i], applied before the synchroniser.
- Synchroniser: two flops per key; s[i] is the second-stage output.
- Debounce, per key:
  - If s[i] == stable[i], the counter resets to 0.
  - Otherwise the counter increments.
  - On a cycle where the counter == DEBOUNCE_CNT-1 and s[i] != stable[i]: stable[i] <= s[i], the counter clears, and flip[i] is asserted for that edge.
  - A glitch shorter than DEBOUNCE_CNT cycles causes no flip.
  - key_state = stable.
  - A raw change held steady updates key_state DEBOUNCE_CNT+2 clock edges after the raw change.
- Pending stage, per key: pend[i] and ptype[i].
  - flip[i] with pend[i] = 0: pend[i] <= 1, ptype[i] <= new stable value.
  - flip[i] with pend[i] = 1 (the opposite-type event is still unqueued): pend[i] <= 0 and overflow <= 1. The cancelling press/release pair is dropped.
- Writer:
  - Each cycle, if any pend bit is set and the FIFO is not full at the start of the cycle, push {i, ptype[i]} for the lowest set index i and clear pend[i].
  - One push per cycle; remaining keys wait.
  - A flip and a write-out on the same key in the same cycle: the write-out takes the old pending event, and the flip sets a new pending event.
- FIFO: show-ahead.
  - evt_valid = (evt_count != 0); evt_idx and evt_press present the head entry.
  - Pop when evt_valid && evt_ready.
  - Push and pop in the same cycle leave evt_count unchanged.
  - No push when full, even if a pop occurs that cycle; the pending bit holds instead, so a full FIFO alone never loses events.
  - Pointers wrap modulo FIFO_DEPTH.
  - Head fields hold stable while evt_valid && !evt_ready.
- Latency: flip at edge E → FIFO write at edge E+1 → evt_valid high after E+1. Raw edge to evt_valid is DEBOUNCE_CNT+3 edges when the queue is empty.
- overflow: set by any dropped pair; cleared by clr_overflow unless a drop occurs in the same cycle, in which case set wins.
- Ready with empty queue: ignored; no pointer movement.

Test Plan (DEBOUNCE_CNT=4, FIFO_DEPTH=4, NUM_KEYS=16, INVERT_MASK=0 unless noted):
- Reset release, raw_keys=0 → all outputs 0. Assert rst mid-debounce of key 3 → key_state 0, no event after release.
- raw_keys[5] 0→1 held, evt_ready=1 → key_state[5]=1 at edge 6 and evt_valid at edge 7 with evt_idx=5, evt_press=1; release gives evt_press=0.
- raw_keys[2] pulsed high for 3 cycles → no key_state change, evt_count stays 0.
- Keys 1, 4 and 9 rise in the same cycle → events emitted in order idx 1, 4, 9 on consecutive edges, each evt_press=1.
- evt_ready=0, 6 distinct presses → evt_count=4, two pend bits held, overflow=0. Raise evt_ready → all 6 events delivered in index order.
- evt_ready=0, FIFO full, key 7 pressed then released past debounce → pair dropped, overflow=1. clr_overflow pulse → overflow=0. INVERT_MASK[0]=1 with raw_keys[0] held low → press event on idx 0.
